// File: rtl/burst_read_arbiter.sv
// burst_read_arbiter
//   Shares one ip2bus burst-read master port between a high-priority video
//   fetch requester (V) and a secondary DMA/CPU requester (C). V wins by
//   default. A run-length guard forces C in after MAX_V_RUN consecutive V
//   grants while C waits. A watchdog aborts a CMD/DATA phase that runs for
//   TIMEOUT cycles.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   v_req/addr/len/gnt      V request, start address, byte length, grant pulse
//   c_req/addr/len/gnt      C request, start address, byte length, grant pulse
//   v_data/valid/done       V read data, beat strobe, burst-complete pulse
//   c_data/valid/done       C read data, beat strobe, burst-complete pulse
//   mst_rd_req/addr/length  command to the master (registered)
//   mst_cmdack              master accepted the command
//   mst_rd_d, mst_src_rdy   read beat data / valid
//   mst_cmplt               master burst complete
//   timeout_err             one-cycle pulse on watchdog abort
//   owner                   current/last owner (0 = V, 1 = C)
module burst_read_arbiter #(
    parameter int MAX_V_RUN = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        v_req,
    input  logic [31:0] v_addr,
    input  logic [11:0] v_len,
    output logic        v_gnt,
    output logic [31:0] v_data,
    output logic        v_valid,
    output logic        v_done,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [11:0] c_len,
    output logic        c_gnt,
    output logic [31:0] c_data,
    output logic        c_valid,
    output logic        c_done,
    output logic        mst_rd_req,
    output logic [31:0] mst_addr,
    output logic [11:0] mst_length,
    input  logic        mst_cmdack,
    input  logic [31:0] mst_rd_d,
    input  logic        mst_src_rdy,
    input  logic        mst_cmplt,
    output logic        timeout_err,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_V_RUN);
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  run_cnt;
    logic [9:0]  wd_cnt;
    logic        zero_len;

    logic        v_win;
    logic        in_burst;
    logic        abort;
    logic [31:0] win_addr;
    logic [11:0] win_len;

    // Grant is combinational so a request sampled in IDLE is granted in the
    // same cycle; it is masked during reset so every output reads 0.
    assign v_win    = v_req && (!c_req || (run_cnt < MAX_RUN));
    assign v_gnt    = (state == IDLE) && !reset && v_win;
    assign c_gnt    = (state == IDLE) && !reset && !v_win && c_req;
    assign win_addr = v_win ? v_addr : c_addr;
    assign win_len  = v_win ? v_len  : c_len;

    // A completion seen in the final watchdog cycle still finishes normally.
    assign in_burst = (state == CMD) || (state == DATA);
    assign abort    = in_burst && (wd_cnt == WD_LAST) &&
                      !((state == DATA) && mst_cmplt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            run_cnt     <= '0;
            wd_cnt      <= '0;
            zero_len    <= 1'b0;
            owner       <= 1'b0;
            mst_rd_req  <= 1'b0;
            mst_addr    <= '0;
            mst_length  <= '0;
            v_data      <= '0;
            c_data      <= '0;
            v_valid     <= 1'b0;
            c_valid     <= 1'b0;
            v_done      <= 1'b0;
            c_done      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            v_valid     <= 1'b0;
            c_valid     <= 1'b0;
            v_done      <= 1'b0;
            c_done      <= 1'b0;
            timeout_err <= 1'b0;

            if (abort) begin
                mst_rd_req  <= 1'b0;
                timeout_err <= 1'b1;
                if (owner) c_done <= 1'b1;
                else       v_done <= 1'b1;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (v_gnt || c_gnt) begin
                            mst_addr   <= win_addr;
                            mst_length <= win_len;
                            owner      <= c_gnt;
                            wd_cnt     <= '0;
                            // Run length only grows while C is actually waiting.
                            if (c_gnt || !c_req)
                                run_cnt <= '0;
                            else if (run_cnt != 4'hF)
                                run_cnt <= run_cnt + 4'd1;
                            if (win_len != 12'd0) begin
                                mst_rd_req <= 1'b1;
                                zero_len   <= 1'b0;
                                state      <= CMD;
                            end else begin
                                zero_len   <= 1'b1;
                                state      <= DONE;
                            end
                        end
                    end
                    CMD: begin
                        wd_cnt <= wd_cnt + 10'd1;
                        if (mst_cmdack) begin
                            mst_rd_req <= 1'b0;
                            state      <= DATA;
                        end
                    end
                    DATA: begin
                        wd_cnt <= wd_cnt + 10'd1;
                        if (mst_src_rdy) begin
                            if (owner) begin
                                c_data  <= mst_rd_d;
                                c_valid <= 1'b1;
                            end else begin
                                v_data  <= mst_rd_d;
                                v_valid <= 1'b1;
                            end
                        end
                        if (mst_cmplt) begin
                            if (owner) c_done <= 1'b1;
                            else       v_done <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        // A zero-length burst spends one extra cycle here and
                        // raises done on its way out, two cycles after grant.
                        if (zero_len) begin
                            zero_len <= 1'b0;
                            if (owner) c_done <= 1'b1;
                            else       v_done <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_burst_read_arbiter.sv
// tb_burst_read_arbiter
//   Self-checking bench for burst_read_arbiter (MAX_V_RUN=4, TIMEOUT=20).
//   Directed steps plus randomized bursts; expected grants come from a small
//   arbitration model, expected beats/done timing from the bench's own
//   transaction bookkeeping.
module tb_burst_read_arbiter;

    localparam int MAXR = 4;
    localparam int TO   = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_req, c_req;
    logic [31:0] v_addr, c_addr;
    logic [11:0] v_len, c_len;
    logic        v_gnt, c_gnt;
    logic [31:0] v_data, c_data;
    logic        v_valid, c_valid, v_done, c_done;
    logic        mst_rd_req;
    logic [31:0] mst_addr;
    logic [11:0] mst_length;
    logic        mst_cmdack;
    logic [31:0] mst_rd_d;
    logic        mst_src_rdy, mst_cmplt;
    logic        timeout_err, owner;

    always #5 clk = ~clk;

    burst_read_arbiter #(.MAX_V_RUN(MAXR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .v_req(v_req), .v_addr(v_addr), .v_len(v_len), .v_gnt(v_gnt),
        .v_data(v_data), .v_valid(v_valid), .v_done(v_done),
        .c_req(c_req), .c_addr(c_addr), .c_len(c_len), .c_gnt(c_gnt),
        .c_data(c_data), .c_valid(c_valid), .c_done(c_done),
        .mst_rd_req(mst_rd_req), .mst_addr(mst_addr), .mst_length(mst_length),
        .mst_cmdack(mst_cmdack), .mst_rd_d(mst_rd_d),
        .mst_src_rdy(mst_src_rdy), .mst_cmplt(mst_cmplt),
        .timeout_err(timeout_err), .owner(owner)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Monitor: record beats, done pulses and timeouts away from the edge.
    logic [31:0] vq[$], cq[$], expq[$];
    int          vdq[$], cdq[$], toq[$];
    int          rdreq_cnt = 0;

    always @(negedge clk) begin
        if (v_valid) vq.push_back(v_data);
        if (c_valid) cq.push_back(c_data);
        if (v_done) vdq.push_back(cyc);
        if (c_done) cdq.push_back(cyc);
        if (timeout_err) toq.push_back(cyc);
        if (mst_rd_req) rdreq_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vq.delete(); cq.delete(); vdq.delete(); cdq.delete(); toq.delete();
        rdreq_cnt = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {v_gnt, c_gnt, v_data, c_data, v_valid, c_valid, v_done, c_done,
                  mst_rd_req, mst_addr, mst_length, timeout_err, owner}, '0);
    endtask

    // Arbitration reference: V keeps the port unless C has been waiting
    // through MAXR consecutive V grants. Returns 1 when C wins.
    int m_run = 0;
    function automatic bit model_arb(input bit v, input bit c);
        bit cw;
        cw = !(v && (!c || m_run < MAXR));
        if (cw || !c) m_run = 0;
        else if (m_run < 15) m_run++;
        return cw;
    endfunction

    // One burst from a single requester; called at posedge+1 in IDLE.
    task automatic burst(input bit who, input logic [31:0] addr, input logic [11:0] len,
                         input int cmd_dly, input bit cnt_data);
        int g, cm, nb, gaps;
        bit ew;
        logic [31:0] d;
        logic [31:0] oq[$], xq[$];
        int dq[$], xdq[$];
        clear_mon();
        expq.delete();
        cm = 0;
        if (who) begin c_req = 1; c_addr = addr; c_len = len; end
        else     begin v_req = 1; v_addr = addr; v_len = len; end
        ew = model_arb(!who, who);
        @(negedge clk);
        chk("gnt_v", v_gnt, !ew);
        chk("gnt_c", c_gnt, ew);
        g = cyc;
        step();
        v_req = 0; c_req = 0;
        nb = int'(len) / 4;
        if (nb == 0) begin
            @(negedge clk);
            chk("zl_length", mst_length, len);
            chk("zl_rdreq", mst_rd_req, 0);
            repeat (3) step();
            chk("zl_rdreq_cnt", rdreq_cnt, 0);
            dq = who ? cdq : vdq;
            xdq = who ? vdq : cdq;
            chk("zl_done_cnt", dq.size(), 1);
            if (dq.size() > 0) chk("zl_done_cyc", dq[0], g + 2);
            chk("zl_other_done", xdq.size(), 0);
        end else begin
            for (int k = 0; k < cmd_dly; k++) begin
                @(negedge clk);
                chk("rdreq_wait", mst_rd_req, 1);
                step();
            end
            mst_cmdack = 1;
            @(negedge clk);
            chk("mst_addr", mst_addr, addr);
            chk("mst_length", mst_length, len);
            chk("owner", owner, who);
            chk("rdreq_cmd", mst_rd_req, 1);
            step();
            mst_cmdack = 0;
            gaps = 0;
            for (int i = 0; i < nb; i++) begin
                if (!cnt_data && gaps < 3 && $urandom_range(0, 3) == 0) begin
                    gaps++;
                    mst_src_rdy = 0; mst_cmplt = 0;
                    step();
                end
                d = cnt_data ? 32'(i) : $urandom;
                mst_src_rdy = 1; mst_rd_d = d; mst_cmplt = (i == nb - 1);
                expq.push_back(d);
                cm = cyc;
                if (i == 0) begin
                    @(negedge clk);
                    chk("rdreq_drop", mst_rd_req, 0);
                end
                step();
            end
            mst_src_rdy = 0; mst_cmplt = 0; mst_rd_d = 0;
            step();
            oq = who ? cq : vq;
            xq = who ? vq : cq;
            dq = who ? cdq : vdq;
            xdq = who ? vdq : cdq;
            chk("done_cnt", dq.size(), 1);
            if (dq.size() > 0) chk("done_cyc", dq[0], cm + 1);
            chk("other_done", xdq.size(), 0);
            chk("beat_cnt", oq.size(), nb);
            for (int i = 0; i < nb && i < oq.size(); i++) chk("beat_data", oq[i], expq[i]);
            chk("other_valid", xq.size(), 0);
            chk("no_timeout", toq.size(), 0);
        end
    endtask

    // Back-to-back one-beat bursts with requests driven by the caller.
    // hold=1 keeps both requests high; otherwise the winner drops its request.
    task automatic arb_run(input bit hold, input int n, output logic [15:0] ord);
        int gc, lastg;
        bit ew;
        logic [31:0] d;
        ord = '0;
        lastg = 0;
        v_len = 12'd4; c_len = 12'd4;
        for (int j = 0; j < n; j++) begin
            ew = model_arb(v_req, c_req);
            @(negedge clk);
            chk("arb_v", v_gnt, !ew);
            chk("arb_c", c_gnt, ew);
            ord[j] = c_gnt;
            gc = cyc;
            if (j > 0) chk("turnaround", gc - lastg, 4);
            lastg = gc;
            step();
            if (!hold) begin
                if (ew) c_req = 0; else v_req = 0;
            end
            mst_cmdack = 1;
            step();
            mst_cmdack = 0;
            d = $urandom;
            mst_src_rdy = 1; mst_cmplt = 1; mst_rd_d = d;
            step();
            mst_src_rdy = 0; mst_cmplt = 0;
            if (j == n - 1) begin v_req = 0; c_req = 0; end
            @(negedge clk);
            chk("arb_valid", ew ? c_valid : v_valid, 1);
            chk("arb_data", ew ? c_data : v_data, d);
            chk("arb_other_valid", ew ? v_valid : c_valid, 0);
            chk("arb_done", ew ? c_done : v_done, 1);
            step();
        end
    endtask

    initial begin
        int g, tcyc;
        bit ew;
        logic [31:0] d, dc;
        logic [31:0] wexp[$];
        logic [15:0] ord;

        reset = 1;
        v_req = 0; c_req = 0;
        v_addr = 0; c_addr = 0; v_len = 0; c_len = 0;
        mst_cmdack = 0; mst_rd_d = 0; mst_src_rdy = 0; mst_cmplt = 0;
        step(); step();
        @(negedge clk);
        chk_all_zero("reset_outputs");
        step();
        reset = 0;
        @(negedge clk);
        chk_all_zero("idle_outputs");
        step();

        // Single directed V burst: 16 counting beats, cmdack one cycle late.
        burst(0, 32'h1000_0000, 12'd64, 1, 1);

        // Randomized single-requester bursts.
        for (int r = 0; r < 10; r++)
            burst(1'($urandom_range(0, 1)), $urandom, 12'($urandom_range(1, 7) * 4),
                  $urandom_range(0, 2), 0);

        // Simultaneous requests, run count zero: V first, C at next IDLE.
        v_req = 1; c_req = 1; v_addr = $urandom; c_addr = $urandom;
        arb_run(0, 2, ord);
        chk("simul_order", ord[1:0], 2'b10);

        // Starvation guard with both requests held high.
        v_req = 1; c_req = 1;
        arb_run(1, 10, ord);
        chk("starve_order", ord[9:0], 10'b1000010000);

        // Zero-length C request never reaches the master.
        burst(1, $urandom, 12'd0, 0, 0);

        // Watchdog: command accepted, two beats, never completes.
        clear_mon();
        v_req = 1; v_addr = $urandom; v_len = 12'd32;
        ew = model_arb(1, 0);
        @(negedge clk);
        chk("wd_gnt", v_gnt, 1);
        g = cyc;
        step();
        v_req = 0; c_req = 1; c_addr = $urandom; c_len = 12'd4;
        mst_cmdack = 1;
        step();
        mst_cmdack = 0;
        wexp.delete();
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            mst_src_rdy = 1; mst_rd_d = d;
            wexp.push_back(d);
            step();
        end
        mst_src_rdy = 0;
        tcyc = -1;
        for (int k = 0; k < 40 && tcyc < 0; k++) begin
            @(negedge clk);
            if (timeout_err) tcyc = cyc;
            else step();
        end
        chk("wd_cycle", tcyc, g + 1 + TO);
        chk("wd_v_done", v_done, 1);
        chk("wd_c_done", c_done, 0);
        ew = model_arb(0, 1);
        chk("wd_c_gnt", c_gnt, ew);
        step();
        c_req = 0;
        for (int i = 0; i < 3; i++) begin
            mst_src_rdy = 1; mst_cmplt = 1; mst_rd_d = $urandom;
            step();
        end
        mst_src_rdy = 0; mst_cmplt = 0;
        @(negedge clk);
        chk("wd_c_owner", owner, 1);
        chk("wd_c_rdreq", mst_rd_req, 1);
        step();
        mst_cmdack = 1;
        step();
        mst_cmdack = 0;
        dc = $urandom;
        mst_src_rdy = 1; mst_cmplt = 1; mst_rd_d = dc;
        step();
        mst_src_rdy = 0; mst_cmplt = 0;
        step(); step();
        chk("wd_v_beats", vq.size(), 2);
        for (int i = 0; i < 2 && i < vq.size(); i++) chk("wd_v_data", vq[i], wexp[i]);
        chk("wd_c_beats", cq.size(), 1);
        if (cq.size() > 0) chk("wd_c_data", cq[0], dc);
        chk("wd_to_cnt", toq.size(), 1);
        chk("wd_v_done_cnt", vdq.size(), 1);
        chk("wd_c_done_cnt", cdq.size(), 1);

        // Reset in the middle of DATA.
        clear_mon();
        v_req = 1; v_addr = $urandom; v_len = 12'd32;
        ew = model_arb(1, 0);
        @(negedge clk);
        chk("mid_gnt", v_gnt, 1);
        step();
        v_req = 0; mst_cmdack = 1;
        step();
        mst_cmdack = 0; mst_src_rdy = 1; mst_rd_d = $urandom;
        step();
        mst_src_rdy = 0;
        reset = 1;
        step();
        @(negedge clk);
        chk_all_zero("mid_reset_outputs");
        step();
        reset = 0;
        m_run = 0;
        @(negedge clk);
        chk_all_zero("post_reset_outputs");
        chk("mid_no_done", vdq.size() + cdq.size(), 0);
        step();
        burst(0, $urandom, 12'd16, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_read_arbiter.md
# burst_read_arbiter

Shares the single AXI burst-read master port (the ip2bus master command/read-data interface) between two requesters: the video framebuffer fetch path (V, high priority) and a secondary DMA/CPU fetch path (C). V owns the port by default; a run-length guard keeps C from starving, and a watchdog recovers the port from a hung transaction. Sits between the requesters' burst logic and the ip2bus master signals.

## Interface

- MAX_V_RUN, 4: consecutive V bursts granted while C is waiting before C is forced in (1..15).
- TIMEOUT, 1023: cycles allowed in CMD+DATA before abort (1..1023, 10-bit counter).
- clk  in  1  system clock (clk_axi domain); all logic on rising edge.
- reset  in  1  synchronous, active-high.
- v_req / c_req  in  1  burst request; held high until matching gnt.
- v_addr / c_addr  in  32  byte start address, sampled at grant.
- v_len / c_len  in  12  byte length, sampled at grant.
- v_gnt / c_gnt  out  1  one-cycle grant pulse.
- v_data / c_data  out  32  registered read data.
- v_valid / c_valid  out  1  one-cycle beat strobe for v_data / c_data.
- v_done / c_done  out  1  one-cycle burst-complete pulse.
- mst_rd_req  out  1  command request to master.
- mst_addr  out  32  latched address.
- mst_length  out  12  latched length.
- mst_cmdack  in  1  master accepted command.
- mst_rd_d  in  32  read beat data.
- mst_src_rdy  in  1  read beat valid.
- mst_cmplt  in  1  burst complete.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- owner  out  1  0=V, 1=C; current/last owner.

## Operation

- States: IDLE, CMD, DATA, DONE.
- IDLE: if any req, arbitrate; latch winner addr/len into mst_addr/mst_length, pulse winner gnt, set owner, clear watchdog. Next: CMD if len≠0, else DONE (zero-length bursts never reach master).
- Arbitration: V wins if v_req and (not c_req or run_cnt < MAX_V_RUN); else C wins when c_req. run_cnt (4-bit) increments on each V grant while c_req=1, clears on any C grant or when c_req=0 at an arbitration point.
- CMD: mst_rd_req=1; on mst_cmdack -> DATA (mst_rd_req drops next cycle).
- DATA: each mst_src_rdy cycle registers mst_rd_d into owner's data and pulses owner's valid next cycle; other requester's valid stays 0. On mst_cmplt (beat in same cycle is still delivered) -> DONE.
- DONE: pulse owner's done, -> IDLE. No arbitration in DONE.
- Watchdog: counts every cycle in CMD/DATA; on reaching TIMEOUT -> pulse timeout_err and owner's done, drop mst_rd_req, -> IDLE. Beats arriving after abort are discarded.
- mst_src_rdy/mst_cmplt outside DATA ignored.

## Timing

- Reset values: all outputs 0; mst_addr/mst_length 0; owner 0; run_cnt 0; state IDLE. Reset mid-burst returns to IDLE in one cycle with no done pulse.
- Grant latency: req high in IDLE at cycle n -> gnt at n, mst_rd_req at n+1.
- Data latency: one cycle from mst_src_rdy to valid.
- done asserted the cycle after mst_cmplt; earliest next grant one cycle after done.
- Minimum burst turnaround (gnt to next gnt): 4 cycles with immediate cmdack and cmplt.
- Requester may drop req after gnt; re-asserting req during its own burst queues a new request.

## Test plan

- Reset: assert reset 2 cycles mid-DATA -> all outputs 0, state IDLE, next v_req gets gnt the cycle it is sampled.
- Single V burst: v_addr=0x1000_0000, v_len=64, cmdack 2 cycles later, 16 beats 0x0..0xF, cmplt with last beat -> mst_addr/length match, 16 v_valid with data 0..F, one v_done, c_valid never high.
- Starvation guard, MAX_V_RUN=4: v_req and c_req held high continuously -> grant order V,V,V,V,C,V,V,V,V,C.
- Simultaneous requests with run_cnt=0 -> V granted first; C granted at next IDLE.
- Zero length: c_req with c_len=0 -> c_gnt, c_done two cycles later, mst_rd_req stays 0.
- Watchdog, TIMEOUT=20: cmdack given, no cmplt -> timeout_err and v_done 20 cycles after entering CMD; late beats produce no v_valid; pending c_req granted next cycle.
